// File: rtl/m_ex_skid_latch.sv
// m_ex_skid_latch: 2-entry skid buffer carrying the swapped operand bundle from M to EX.
// Define M_EX_STALL_CNT_EN to add the saturating back-pressure counter on stall_cnt.
module m_ex_skid_latch #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TYPE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic [DATA_WIDTH-1:0] in_op2,
  input  logic [DATA_WIDTH-1:0] in_op3,
  input  logic [DATA_WIDTH-1:0] in_op4,
  input  logic [DATA_WIDTH-1:0] in_ptc1,
  input  logic [DATA_WIDTH-1:0] in_ptc2,
  input  logic [DATA_WIDTH-1:0] in_ptc3,
  input  logic [DATA_WIDTH-1:0] in_ptc4,
  input  logic [ADDR_WIDTH-1:0] in_daddr1,
  input  logic [ADDR_WIDTH-1:0] in_daddr2,
  input  logic [ADDR_WIDTH-1:0] in_daddr3,
  input  logic [ADDR_WIDTH-1:0] in_daddr4,
  input  logic [TYPE_WIDTH-1:0] in_dtype1,
  input  logic [TYPE_WIDTH-1:0] in_dtype2,
  input  logic [TYPE_WIDTH-1:0] in_dtype3,
  input  logic [TYPE_WIDTH-1:0] in_dtype4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [DATA_WIDTH-1:0] out_op3,
  output logic [DATA_WIDTH-1:0] out_op4,
  output logic [DATA_WIDTH-1:0] out_ptc1,
  output logic [DATA_WIDTH-1:0] out_ptc2,
  output logic [DATA_WIDTH-1:0] out_ptc3,
  output logic [DATA_WIDTH-1:0] out_ptc4,
  output logic [ADDR_WIDTH-1:0] out_daddr1,
  output logic [ADDR_WIDTH-1:0] out_daddr2,
  output logic [ADDR_WIDTH-1:0] out_daddr3,
  output logic [ADDR_WIDTH-1:0] out_daddr4,
  output logic [TYPE_WIDTH-1:0] out_dtype1,
  output logic [TYPE_WIDTH-1:0] out_dtype2,
  output logic [TYPE_WIDTH-1:0] out_dtype3,
  output logic [TYPE_WIDTH-1:0] out_dtype4
`ifdef M_EX_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int BW = 8*DATA_WIDTH + 4*ADDR_WIDTH + 4*TYPE_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;
  logic [BW-1:0] in_bundle_s;
  logic          push_s, pop_s;

  assign in_bundle_s = {in_op1, in_op2, in_op3, in_op4,
                        in_ptc1, in_ptc2, in_ptc3, in_ptc4,
                        in_daddr1, in_daddr2, in_daddr3, in_daddr4,
                        in_dtype1, in_dtype2, in_dtype3, in_dtype4};

  // Handshake flags come straight off the state flop, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  assign {out_op1, out_op2, out_op3, out_op4,
          out_ptc1, out_ptc2, out_ptc3, out_ptc4,
          out_daddr1, out_daddr2, out_daddr3, out_daddr4,
          out_dtype1, out_dtype2, out_dtype3, out_dtype4} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            main_d  = in_bundle_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            main_d = in_bundle_s;
          end else if (push_s) begin
            state_d = ST_TWO;
            skid_d  = in_bundle_s;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // Older bundle stays in MAIN; SKID only moves up once MAIN drains.
          if (pop_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= {BW{1'b0}};
      skid_q  <= {BW{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef M_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt = stall_cnt_q;

  always_comb begin
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Only reset clears the counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_m_ex_skid_latch.sv
// Bench for m_ex_skid_latch: a depth-2 FIFO scoreboard predicts handshake flags and bundle order.
module tb_m_ex_skid_latch;
  localparam int BW = 652;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [3:0][63:0] i_op, i_ptc, o_op, o_ptc;
  logic [3:0][31:0] i_da, o_da;
  logic [3:0][2:0]  i_dt, o_dt;
  logic [BW-1:0]    out_b;
`ifdef M_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_m = 32'd0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  bit mdl_en = 1'b0;
  logic [BW-1:0] exp_q[$];

  m_ex_skid_latch dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(i_op[0]), .in_op2(i_op[1]), .in_op3(i_op[2]), .in_op4(i_op[3]),
    .in_ptc1(i_ptc[0]), .in_ptc2(i_ptc[1]), .in_ptc3(i_ptc[2]), .in_ptc4(i_ptc[3]),
    .in_daddr1(i_da[0]), .in_daddr2(i_da[1]), .in_daddr3(i_da[2]), .in_daddr4(i_da[3]),
    .in_dtype1(i_dt[0]), .in_dtype2(i_dt[1]), .in_dtype3(i_dt[2]), .in_dtype4(i_dt[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(o_op[0]), .out_op2(o_op[1]), .out_op3(o_op[2]), .out_op4(o_op[3]),
    .out_ptc1(o_ptc[0]), .out_ptc2(o_ptc[1]), .out_ptc3(o_ptc[2]), .out_ptc4(o_ptc[3]),
    .out_daddr1(o_da[0]), .out_daddr2(o_da[1]), .out_daddr3(o_da[2]), .out_daddr4(o_da[3]),
    .out_dtype1(o_dt[0]), .out_dtype2(o_dt[1]), .out_dtype3(o_dt[2]), .out_dtype4(o_dt[3])
`ifdef M_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign out_b = {o_op, o_ptc, o_da, o_dt};

  function automatic logic [BW-1:0] pack_in();
    return {i_op, i_ptc, i_da, i_dt};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rand_bundle();
    for (int k = 0; k < 4; k++) begin
      i_op[k]  = {$urandom(), $urandom()};
      i_ptc[k] = {$urandom(), $urandom()};
      i_da[k]  = $urandom();
      i_dt[k]  = 3'($urandom_range(7, 0));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor compares against the scoreboard head, then the model absorbs this cycle's inputs.
  always @(negedge clk) begin
    int sz;
    if (mdl_en) begin
      sz = exp_q.size();
      chk("out_valid", {651'd0, out_valid}, {651'd0, sz != 0});
      chk("in_ready", {651'd0, in_ready}, {651'd0, sz < 2});
      if (sz != 0) chk("bundle", out_b, exp_q[0]);
`ifdef M_EX_STALL_CNT_EN
      chk("stall_cnt", {620'd0, stall_cnt}, {620'd0, stall_m});
      if (sz != 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && sz < 2) exp_q.push_back(pack_in());
      end
    end
  end

  initial begin
    rand_bundle();
    #12;
    chk("rst_out_valid", {651'd0, out_valid}, {BW{1'b0}});
    chk("rst_in_ready", {651'd0, in_ready}, {651'd0, 1'b1});
    chk("rst_bundle", out_b, {BW{1'b0}});
    rst = 1'b1;
    cyc();
    mdl_en = 1'b1;

    // Test 1: single push with known fields
    rand_bundle();
    i_op[0] = 64'hDEAD_BEEF_0000_0001;
    i_da[0] = 32'h0000_1000;
    i_dt[0] = 3'b100;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t1_valid", {651'd0, out_valid}, {651'd0, 1'b1});
    chk("t1_op1", {588'd0, o_op[0]}, {588'd0, 64'hDEAD_BEEF_0000_0001});
    chk("t1_daddr1", {620'd0, o_da[0]}, {620'd0, 32'h0000_1000});
    chk("t1_dtype1", {649'd0, o_dt[0]}, {649'd0, 3'b100});
    cyc();
    chk("t1_empty", {651'd0, out_valid}, {BW{1'b0}});

    // Test 2: back-pressure with A then B
    out_ready = 1'b0;
    rand_bundle();
    in_valid = 1'b1;
    cyc();
    rand_bundle();
    cyc();
    in_valid = 1'b0;
    chk("t2_full", {651'd0, in_ready}, {BW{1'b0}});
    repeat (3) cyc();
    out_ready = 1'b1;
    repeat (3) cyc();

    // Test 3: streaming op1 = 0..7
    for (int i = 0; i < 8; i++) begin
      rand_bundle();
      i_op[0] = 64'(i);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    // Test 4: flush in TWO with simultaneous push
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_bundle();
    cyc();
    rand_bundle();
    cyc();
    rand_bundle();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_valid", {651'd0, out_valid}, {BW{1'b0}});
    chk("t4_ready", {651'd0, in_ready}, {651'd0, 1'b1});
    out_ready = 1'b1;
    repeat (3) cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_bundle();
      in_valid = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0;
      flush = ($urandom_range(31, 0) == 0) ? 1'b1 : 1'b0;
      cyc();
    end
    flush = 1'b0;

    // Test 5: async reset mid-cycle while in TWO
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_bundle();
    cyc();
    rand_bundle();
    cyc();
    in_valid = 1'b0;
    cyc();
    #2;
    mdl_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_valid", {651'd0, out_valid}, {BW{1'b0}});
    chk("t5_ready", {651'd0, in_ready}, {651'd0, 1'b1});
    chk("t5_bundle", out_b, {BW{1'b0}});
    exp_q.delete();
`ifdef M_EX_STALL_CNT_EN
    stall_m = 32'd0;
`endif
    cyc();
    rst = 1'b1;
    mdl_en = 1'b1;
    cyc();

`ifdef M_EX_STALL_CNT_EN
    // Test 6: stall counter
    rand_bundle();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();
    chk("t6_cnt5", {620'd0, stall_cnt}, {620'd0, 32'd5});
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t6_flush", {620'd0, stall_cnt}, {620'd0, 32'd5});
    #2;
    mdl_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst", {620'd0, stall_cnt}, {BW{1'b0}});
    exp_q.delete();
    stall_m = 32'd0;
    cyc();
    rst = 1'b1;
    mdl_en = 1'b1;
    cyc();
`endif

    repeat (2) cyc();
    mdl_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
